// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event receiver.
// Entry 0 of the scan-code table sits in the least significant byte.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int PS2_TABLE_SIZE = 16;

    localparam logic [127:0] PS2_SCAN_TABLE = {
        8'h3C, 8'h35, 8'h2C, 8'h2D, 8'h24, 8'h1D, 8'h15, 8'h46,
        8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16
    };

    typedef struct packed {
        logic [3:0] index;
        logic       is_release;
        logic       is_extended;
    } ps2_key_evt_t;

    function automatic logic [7:0] ps2_scan_code(input int unsigned idx);
        return PS2_SCAN_TABLE[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: synchroniser, tick divider, 11-bit frame FSM with stall timeout.
// byte_valid and frame_err are single-clk pulses decoded from the registered FSM state.
module ps2_frame_rx #(
    parameter int TICK_DIV      = 249,
    parameter int TIMEOUT_TICKS = 4000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int DIV_W   = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam int STALL_W = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic [1:0]         clk_sync_reg, data_sync_reg;
    logic [DIV_W-1:0]   div_cnt_reg;
    logic               clk_sample_reg;
    logic [1:0]         state_reg;
    logic [3:0]         bit_cnt_reg;
    logic [10:0]        frame_reg;
    logic [STALL_W-1:0] stall_reg;

    logic tick, fall, data_bit, frame_ok, timeout_hit;

    assign tick        = (div_cnt_reg == DIV_W'(TICK_DIV));
    assign fall        = tick && clk_sample_reg && !clk_sync_reg[1];
    assign data_bit    = data_sync_reg[1];
    // frame_reg[0] = start, [8:1] = d0..d7, [9] = parity, [10] = stop
    assign frame_ok    = !frame_reg[0] && frame_reg[10] && (^frame_reg[9:1]);
    assign timeout_hit = (state_reg == SHIFT) && tick && !fall
                         && (stall_reg == STALL_W'(TIMEOUT_TICKS - 1));

    assign byte_valid = (state_reg == CHECK) && frame_ok;
    assign rx_byte    = frame_reg[8:1];
    assign frame_err  = ((state_reg == CHECK) && !frame_ok) || timeout_hit;

    // Sync flops idle high so reset never manufactures a falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_reg   <= 2'b11;
            data_sync_reg  <= 2'b11;
            div_cnt_reg    <= '0;
            clk_sample_reg <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            div_cnt_reg   <= tick ? '0 : div_cnt_reg + 1'b1;
            if (tick) begin
                clk_sample_reg <= clk_sync_reg[1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            frame_reg   <= '0;
            stall_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fall) begin
                        frame_reg   <= {data_bit, frame_reg[10:1]};
                        bit_cnt_reg <= 4'd1;
                        stall_reg   <= '0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        frame_reg <= {data_bit, frame_reg[10:1]};
                        stall_reg <= '0;
                        if (bit_cnt_reg == 4'd10) begin
                            state_reg <= CHECK;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_reg <= IDLE;
                    end else if (tick) begin
                        stall_reg <= stall_reg + 1'b1;
                    end
                end
                CHECK:   state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard to key-event converter: prefix decoding, scan-code lookup,
// first-word-fall-through event FIFO, held-key bitmap and timed last-key register.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int NUM_KEYS      = 16,
    parameter int TICK_DIV      = 249,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int HOLD_CYCLES   = 10000000,
    parameter int FIFO_DEPTH    = 4,
    parameter int IDX_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [IDX_W-1:0]    key_index,
    output logic                key_release,
    output logic                key_extended,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [IDX_W-1:0]    last_key,
    output logic                last_key_valid,
    output logic                frame_err,
    output logic                fifo_ovf
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [1:0] D_IDLE    = 2'd0;
    localparam logic [1:0] D_EXT     = 2'd1;
    localparam logic [1:0] D_BRK     = 2'd2;
    localparam logic [1:0] D_EXT_BRK = 2'd3;

    logic       byte_valid;
    logic [7:0] rx_byte;

    ps2_frame_rx #(
        .TICK_DIV      (TICK_DIV),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_frame_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    // Scan-code lookup; the downward loop leaves the lowest matching index
    logic [NUM_KEYS-1:0] code_match;
    logic                hit;
    logic [3:0]          hit_idx;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
        assign code_match[gi] = (rx_byte == ps2_scan_code(gi));
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (code_match[i]) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    logic [1:0]   dstate_reg;
    logic         evt_valid_reg;
    ps2_key_evt_t evt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dstate_reg    <= D_IDLE;
            evt_valid_reg <= 1'b0;
            evt_reg       <= '0;
        end else begin
            evt_valid_reg <= 1'b0;
            if (frame_err) begin
                dstate_reg <= D_IDLE;
            end else if (byte_valid) begin
                if (rx_byte == PS2_EXT) begin
                    dstate_reg <= (dstate_reg == D_IDLE) ? D_EXT : D_IDLE;
                end else if (rx_byte == PS2_BRK) begin
                    case (dstate_reg)
                        D_IDLE:  dstate_reg <= D_BRK;
                        D_EXT:   dstate_reg <= D_EXT_BRK;
                        default: dstate_reg <= D_IDLE;
                    endcase
                end else begin
                    evt_valid_reg       <= hit;
                    evt_reg.index       <= hit_idx;
                    evt_reg.is_release  <= (dstate_reg == D_BRK) || (dstate_reg == D_EXT_BRK);
                    evt_reg.is_extended <= (dstate_reg == D_EXT) || (dstate_reg == D_EXT_BRK);
                    dstate_reg          <= D_IDLE;
                end
            end
        end
    end

    // Event FIFO with an extra wrap bit on each pointer to tell full from empty
    ps2_key_evt_t     fifo_mem [FIFO_DEPTH];
    ps2_key_evt_t     head;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic             empty, full, pop, push;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1])
                   && (wr_ptr_reg[PTR_W-2:0] == rd_ptr_reg[PTR_W-2:0]);
    assign pop   = !empty && key_ready;
    assign push  = evt_valid_reg && (!full || pop);
    assign head  = fifo_mem[rd_ptr_reg[PTR_W-2:0]];

    assign key_valid    = !empty;
    assign key_index    = key_valid ? head.index[IDX_W-1:0] : '0;
    assign key_release  = key_valid && head.is_release;
    assign key_extended = key_valid && head.is_extended;
    assign fifo_ovf     = evt_valid_reg && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-2:0]] <= evt_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Held-key bitmap updates even when the FIFO drops the event
    logic [NUM_KEYS-1:0] key_held_reg;
    assign key_held = key_held_reg;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_held
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                key_held_reg[gi] <= 1'b0;
            end else if (evt_valid_reg && (evt_reg.index == 4'(gi))) begin
                key_held_reg[gi] <= !evt_reg.is_release;
            end
        end
    end

    logic [IDX_W-1:0]  last_key_reg;
    logic              last_key_valid_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic              make_evt;

    assign make_evt       = evt_valid_reg && !evt_reg.is_release;
    assign last_key       = last_key_reg;
    assign last_key_valid = last_key_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key_reg       <= '0;
            last_key_valid_reg <= 1'b0;
            hold_cnt_reg       <= '0;
        end else if (make_evt) begin
            last_key_reg       <= evt_reg.index[IDX_W-1:0];
            last_key_valid_reg <= 1'b1;
            hold_cnt_reg       <= '0;
        end else if (last_key_valid_reg) begin
            if (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
                last_key_reg       <= '0;
                last_key_valid_reg <= 1'b0;
                hold_cnt_reg       <= '0;
            end else begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
Parametrised PS/2 keyboard receiver that turns raw ps2_clk/ps2_data into discrete key events for the PISA keypad path.
- Decodes full frames with start, parity and stop checks, and a stall timeout.
- Handles E0 (extended) and F0 (break) prefixes.
- Maps scan codes to key indices, buffers events in a FIFO with a valid/ready handshake, and keeps a held-key bitmap plus a timed "last key" register for LED/quadrant consumers.

Parameters:
NUM_KEYS, 16, number of mapped keys (1..16); indices 0..NUM_KEYS-1 use the first NUM_KEYS entries of the package scan-code table.
TICK_DIV, 249, clk cycles between line-sample ticks (tick period = TICK_DIV+1 clk).
TIMEOUT_TICKS, 4000, ticks without a falling ps2_clk edge mid-frame before the frame is aborted.
HOLD_CYCLES, 10000000, clk cycles last_key stays valid after the most recent make event.
FIFO_DEPTH, 4, event FIFO entries; must be a power of two and ≥2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ps2_clk  in  1  raw PS/2 clock (asynchronous)
ps2_data  in  1  raw PS/2 data (asynchronous)
key_valid  out  1  FIFO head holds an event
key_ready  in  1  consumer accepts the head event when key_valid && key_ready
key_index  out  IDX_W  head event key index, where IDX_W=max(1,$clog2(NUM_KEYS))
key_release  out  1  head event is a break (release)
key_extended  out  1  head event was E0-prefixed
key_held  out  NUM_KEYS  bit i=1 while key i is pressed
last_key  out  IDX_W  index of the most recent make
last_key_valid  out  1  last_key is fresh (within HOLD_CYCLES)
frame_err  out  1  one-clk pulse on parity, start, stop or timeout error
fifo_ovf  out  1  one-clk pulse when an event is dropped because the FIFO is full

Behaviour:
Reset is asynchronous on rst_n low. Every output goes to 0 and both FSMs go to IDLE/D_IDLE. A reset mid-frame discards the partial frame.

Input synchronisation and sampling:
- ps2_clk and ps2_data pass through a 2-flop synchroniser.
- A free-running divider asserts tick for 1 clk every TICK_DIV+1 clk.
- The line is sampled only on tick. A falling edge is prev_sample=1 and cur_sample=0.

Frame FSM (IDLE, SHIFT, CHECK):
- IDLE: on a falling edge, capture data as the start bit and go to SHIFT with bitcnt=1.
- SHIFT: each falling edge shifts data in. After bit 11 (start, d0..d7 LSB first, parity, stop), go to CHECK.
- CHECK, one clk:
  - ok = start==0, stop==1, and odd parity over d0..d7 plus parity.
  - ok → byte_valid pulse with the byte.
  - not ok → frame_err pulse.
  - Return to IDLE.
- In SHIFT, a stall counter counts ticks without a falling edge and resets on each edge. Reaching TIMEOUT_TICKS → frame_err pulse, go to IDLE.

Decode FSM (D_IDLE, D_EXT, D_BRK, D_EXT_BRK), advancing on byte_valid:
- E0 from D_IDLE → D_EXT.
- F0 from D_IDLE → D_BRK; F0 from D_EXT → D_EXT_BRK.
- Any other byte:
  - Look the code up in the table; the lowest matching index wins.
  - release=(state is BRK or EXT_BRK); extended=(state is EXT or EXT_BRK).
  - On a hit, generate an event. On a miss, generate no event.
  - Either way, return to D_IDLE.
- E0 or F0 received in any other state returns the FSM to D_IDLE with no event.
- A frame_err returns the FSM to D_IDLE.

Event side effects, applied in the clk after byte_valid:
- Push {index, release, extended} to the FIFO.
- Make: set key_held[index]. Load last_key, set last_key_valid, clear hold_cnt.
- Break: clear key_held[index]. last_key is untouched.
- A repeated make (typematic) re-arms last_key.

Hold timer:
- While last_key_valid=1 and no make occurs, hold_cnt increments each clk.
- When hold_cnt reaches HOLD_CYCLES-1, clear last_key_valid and last_key.

FIFO:
- Registered and first-word-fall-through.
- key_valid=!empty; outputs show the head.
- The first event reaches key_valid 2 clk after byte_valid.
- Simultaneous push and pop when full is allowed (no overflow).
- Push when full without a pop → event dropped, fifo_ovf pulse. key_held and last_key still update.
- Pointers wrap modulo FIFO_DEPTH using an extra wrap bit.

Decomposition:
Shared package ps2_pkg:
- ps2_key_evt_t struct {index, release, extended}.
- Localparams PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
- 16-entry scan-code table: 16,1E,26,25,2E,36,3D,3E,46,15,1D,24,2D,2C,35,3C.

One sub-module, ps2_frame_rx: synchroniser, tick divider, frame FSM and timeout; outputs byte_valid, byte and frame_err. The top level holds the decode FSM, table lookup, FIFO, bitmap and hold timer.

Test Plan:
- Make: frame 8'h16 with correct parity → within 2 clk of byte_valid, key_valid=1, key_index=0, key_release=0, key_held=16'h0001, last_key=0, last_key_valid=1; key_ready=1 pops it.
- Break and extended: frames E0,F0,1E → one event with index=1, release=1, extended=1; key_held bit1 cleared; last_key unchanged.
- Parity error: frame 8'h1E with even parity → frame_err pulses once, no event; a following good 8'h26 yields index=2.
- Timeout: 5 falling edges then idle for TIMEOUT_TICKS ticks → frame_err pulse, FSM back to IDLE; next full frame 8'h25 yields index=3.
- Overflow: FIFO_DEPTH=4, key_ready=0, makes 16,1E,26,25,2E → 4 events held, fifo_ovf pulses on the 5th; pops return indices 0,1,2,3 in order; key_held=16'h001F.
- Hold expiry and reset: HOLD_CYCLES=100, one make of 3C → last_key=15 valid for exactly 100 clk then cleared. Assert rst_n low mid-frame → all outputs 0; the following frame decodes correctly.
